// File: rtl/axi_rd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : axi_rd_sched
//  Purpose  : Shares one AXI3 read-address / read-data port between the
//             instruction cache (i_*) and the data-side arbiter (d_*).
//             One burst is outstanding at a time. The data side is
//             preferred, but the instruction side wins once it has waited
//             STARVE_LIMIT cycles or more.
//  Ports    : aclk, aresetn (sync, active low)
//             i_ar* / d_ar*   requester AR channels (arready is combinational)
//             i_r*  / d_r*    requester R channels (routed to the owner only)
//             ar*, r*         outer AXI3 AR/R port (arid 0 = i, 1 = d)
//  Revision : 1.0  initial release
// ============================================================================
module axi_rd_sched #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    // instruction-side requester
    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    // data-side requester
    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    // outer AXI3 read port
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_STARVE_LIMIT = CNT_W'(STARVE_LIMIT);

    state_t             state_q,   state_d;
    logic               owner_q,   owner_d;     // 0 = i, 1 = d
    logic [CNT_W-1:0]   wait_q,    wait_d;
    logic [3:0]         arid_q,    arid_d;
    logic [31:0]        araddr_q,  araddr_d;
    logic [7:0]         arlen_q,   arlen_d;
    logic [2:0]         arsize_q,  arsize_d;
    logic               arvalid_q, arvalid_d;

    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_in_data;
    logic               w_rready;

    // R routing is only live in DATA and is forced low while in reset.
    assign w_in_data = aresetn && (state_q == DATA);
    assign w_rready  = w_in_data && (owner_q ? d_rready : i_rready);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wait_d    = wait_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arvalid_d = arvalid_q;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;

        case (state_q)
            IDLE: begin
                // d is preferred unless i has been starved long enough.
                if (i_arvalid && (!d_arvalid || (wait_q >= c_STARVE_LIMIT))) begin
                    w_grant_i = 1'b1;
                end else if (d_arvalid) begin
                    w_grant_d = 1'b1;
                end
                if (w_grant_i || w_grant_d) begin
                    owner_d   = w_grant_d;
                    arid_d    = w_grant_d ? 4'd1 : 4'd0;
                    araddr_d  = w_grant_d ? d_araddr : i_araddr;
                    arlen_d   = w_grant_d ? d_arlen  : i_arlen;
                    arsize_d  = w_grant_d ? d_arsize : i_arsize;
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (rvalid && w_rready && rlast) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The starvation count keeps running while the bus is busy, so i
        // usually has priority at the first IDLE after a long d burst.
        if (w_grant_i) begin
            wait_d = '0;
        end else if (i_arvalid && (wait_q != {CNT_W{1'b1}})) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            wait_q    <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wait_q    <= wait_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arvalid_q <= arvalid_d;
        end
    end

    assign i_arready = aresetn && w_grant_i;
    assign d_arready = aresetn && w_grant_d;

    assign arid      = arid_q;
    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arsize    = arsize_q;
    assign arvalid   = arvalid_q;

    assign rready    = w_rready;
    assign i_rdata   = rdata;
    assign d_rdata   = rdata;
    assign i_rvalid  = w_in_data && !owner_q && rvalid;
    assign i_rlast   = w_in_data && !owner_q && rlast;
    assign d_rvalid  = w_in_data &&  owner_q && rvalid;
    assign d_rlast   = w_in_data &&  owner_q && rlast;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_rd_sched
//  Purpose  : Randomised scoreboard bench for axi_rd_sched. A driver acts as
//             both requesters and the outer AXI slave, predicts grants with
//             an abstract bus model and queues the expected AR and R traffic;
//             a monitor compares the DUT outputs against those queues.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_rd_sched;

    localparam int STARVE_LIMIT = 8;
    localparam int CNT_W        = 4;
    localparam int N_CYCLES     = 4000;
    localparam int N_DRAIN      = 200;
    localparam int RST_AT       = 2500;
    localparam int WAIT_MAX     = (1 << CNT_W) - 1;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] i_araddr = '0, d_araddr = '0;
    logic [7:0]  i_arlen = '0,  d_arlen = '0;
    logic [2:0]  i_arsize = '0, d_arsize = '0;
    logic        i_arvalid = 1'b0, d_arvalid = 1'b0;
    logic        i_arready, d_arready;
    logic [31:0] i_rdata, d_rdata;
    logic        i_rlast, d_rlast, i_rvalid, d_rvalid;
    logic        i_rready = 1'b0, d_rready = 1'b0;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rlast = 1'b0, rvalid = 1'b0;
    logic        rready;

    axi_rd_sched #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arvalid(i_arvalid), .i_arready(i_arready), .i_rdata(i_rdata),
        .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
        .d_arvalid(d_arvalid), .d_arready(d_arready), .d_rdata(d_rdata),
        .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready), .rdata(rdata), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    ar_t   ar_q[$];
    beat_t exp_i_q[$];
    beat_t exp_d_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    bit stim_done = 1'b0;

    // Abstract bus model: busy from grant until the last beat is taken;
    // addr_pend marks the span where the outer AR should still be presented.
    bit m_busy = 1'b0;
    bit m_pend = 1'b0;
    bit m_owner = 1'b0;
    int m_wait = 0;

    function automatic logic [31:0] beat_data(input logic [31:0] a, input int k);
        return a ^ (32'(k) * 32'h0100_0193) ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: requesters, outer slave and reference model
    // ------------------------------------------------------------------
    initial begin
        bit s_i_hs, s_d_hs, s_ar_hs, s_r_hs;
        logic [31:0] s_araddr;
        logic [7:0]  s_arlen;
        bit i_act = 1'b0, d_act = 1'b0, first_i = 1'b1, rst_done = 1'b0;
        bit sl_act = 1'b0;
        logic [31:0] sl_addr = '0;
        int sl_len = 0, sl_beat = 0, rst_cnt = 0;
        bit gi, gd, xrr;
        ar_t a;
        beat_t b;

        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;

        for (int cyc = 0; cyc < N_CYCLES + N_DRAIN; cyc++) begin
            @(negedge aclk);
            s_i_hs   = i_arvalid && i_arready;
            s_d_hs   = d_arvalid && d_arready;
            s_ar_hs  = arvalid && arready;
            s_r_hs   = rvalid && rready;
            s_araddr = araddr;
            s_arlen  = arlen;

            @(posedge aclk);
            // reference model step for this edge
            if (!aresetn) begin
                m_busy = 1'b0; m_pend = 1'b0; m_owner = 1'b0; m_wait = 0;
            end else begin
                gi  = !m_busy && i_arvalid && (!d_arvalid || m_wait >= STARVE_LIMIT);
                gd  = !m_busy && d_arvalid && !gi;
                xrr = m_owner ? d_rready : i_rready;
                if (m_busy && m_pend && arready)
                    m_pend = 1'b0;
                else if (m_busy && !m_pend && rvalid && xrr && rlast)
                    m_busy = 1'b0;
                if (gi || gd) begin
                    a.id   = gd ? 4'd1 : 4'd0;
                    a.addr = gd ? d_araddr : i_araddr;
                    a.len  = gd ? d_arlen  : i_arlen;
                    a.size = gd ? d_arsize : i_arsize;
                    ar_q.push_back(a);
                    for (int k = 0; k <= int'(a.len); k++) begin
                        b.data = beat_data(a.addr, k);
                        b.last = (k == int'(a.len));
                        if (gd) exp_d_q.push_back(b);
                        else    exp_i_q.push_back(b);
                    end
                    m_busy = 1'b1; m_pend = 1'b1; m_owner = gd;
                end
                if (gi)
                    m_wait = 0;
                else if (i_arvalid && m_wait < WAIT_MAX)
                    m_wait = m_wait + 1;
            end

            #1;
            // reset sequencing: one abort while a burst is in its data phase
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) aresetn = 1'b1;
            end else if (!rst_done && cyc >= RST_AT && m_busy && !m_pend && sl_act) begin
                aresetn  = 1'b0;
                rst_cnt  = 2;
                rst_done = 1'b1;
            end

            // requesters
            if (s_i_hs) i_act = 1'b0;
            if (s_d_hs) d_act = 1'b0;
            if (!aresetn) begin
                i_act = 1'b0; d_act = 1'b0;
            end else begin
                if (!i_act && cyc < N_CYCLES && (first_i || $urandom_range(0, 99) < 30)) begin
                    i_act = 1'b1;
                    if (first_i) begin
                        i_araddr = 32'h1FC0_0000; i_arlen = 8'd7; i_arsize = 3'd2;
                        first_i  = 1'b0;
                    end else begin
                        i_araddr = $urandom & 32'hFFFF_FFFC;
                        i_arlen  = 8'($urandom_range(0, 7));
                        i_arsize = 3'($urandom_range(0, 2));
                    end
                end
                // d stays quiet at first so the opening i burst runs alone
                if (!d_act && cyc >= 30 && cyc < N_CYCLES && $urandom_range(0, 99) < 75) begin
                    d_act    = 1'b1;
                    d_araddr = $urandom & 32'hFFFF_FFFC;
                    d_arlen  = 8'($urandom_range(0, 7));
                    d_arsize = 3'($urandom_range(0, 2));
                end
            end
            i_arvalid = i_act;
            d_arvalid = d_act;
            i_rready  = ($urandom_range(0, 3) != 0);
            d_rready  = ($urandom_range(0, 1) != 0);

            // outer slave; arready is forced low in periodic windows
            arready = ((cyc % 50) >= 6) && ($urandom_range(0, 2) == 0);
            if (!aresetn) begin
                sl_act = 1'b0;
                rvalid = 1'b0;
                rlast  = 1'b0;
            end else begin
                if (s_ar_hs) begin
                    sl_act = 1'b1; sl_addr = s_araddr; sl_len = int'(s_arlen); sl_beat = 0;
                end
                if (s_r_hs) begin
                    if (sl_beat == sl_len) sl_act = 1'b0;
                    else sl_beat++;
                end
                if (!rvalid || s_r_hs)
                    rvalid = sl_act && ($urandom_range(0, 3) != 0);
                rdata = beat_data(sl_addr, sl_beat);
                rlast = (sl_beat == sl_len);
            end
        end
        stim_done = 1'b1;
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        int  rst_cyc;
        bit  xgi, xgd, xdata, xrr;
        ar_t a;
        beat_t b;
        rst_cyc = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) rst_cyc++;
            else rst_cyc = 0;

            xgi   = aresetn && !m_busy && i_arvalid && (!d_arvalid || m_wait >= STARVE_LIMIT);
            xgd   = aresetn && !m_busy && d_arvalid && !xgi;
            xdata = aresetn && m_busy && !m_pend;
            xrr   = xdata && (m_owner ? d_rready : i_rready);

            chk("i_arready", 64'(i_arready), 64'(xgi));
            chk("d_arready", 64'(d_arready), 64'(xgd));
            chk("rready",    64'(rready),    64'(xrr));
            chk("i_rvalid",  64'(i_rvalid),  64'(xdata && !m_owner && rvalid));
            chk("d_rvalid",  64'(d_rvalid),  64'(xdata &&  m_owner && rvalid));
            chk("i_rlast",   64'(i_rlast),   64'(xdata && !m_owner && rlast));
            chk("d_rlast",   64'(d_rlast),   64'(xdata &&  m_owner && rlast));
            chk("i_rdata",   64'(i_rdata),   64'(rdata));
            chk("d_rdata",   64'(d_rdata),   64'(rdata));

            if (aresetn || rst_cyc >= 2)
                chk("arvalid", 64'(arvalid), 64'(m_busy && m_pend));

            if (rst_cyc >= 2) begin
                chk("rst_arid",   64'(arid),   64'd0);
                chk("rst_araddr", 64'(araddr), 64'd0);
                chk("rst_arlen",  64'(arlen),  64'd0);
                chk("rst_arsize", 64'(arsize), 64'd0);
            end

            if (aresetn && arvalid) begin
                if (ar_q.size() == 0) begin
                    chk("ar_unexpected", 64'(arvalid), 64'd0);
                end else begin
                    a = ar_q[0];
                    chk("arid",   64'(arid),   64'(a.id));
                    chk("araddr", 64'(araddr), 64'(a.addr));
                    chk("arlen",  64'(arlen),  64'(a.len));
                    chk("arsize", 64'(arsize), 64'(a.size));
                    if (arready) void'(ar_q.pop_front());
                end
            end

            if (i_rvalid && i_rready) begin
                if (exp_i_q.size() == 0) begin
                    chk("i_beat_unexpected", 64'(i_rvalid), 64'd0);
                end else begin
                    b = exp_i_q.pop_front();
                    chk("i_beat_data", 64'(i_rdata), 64'(b.data));
                    chk("i_beat_last", 64'(i_rlast), 64'(b.last));
                end
            end
            if (d_rvalid && d_rready) begin
                if (exp_d_q.size() == 0) begin
                    chk("d_beat_unexpected", 64'(d_rvalid), 64'd0);
                end else begin
                    b = exp_d_q.pop_front();
                    chk("d_beat_data", 64'(d_rdata), 64'(b.data));
                    chk("d_beat_last", 64'(d_rlast), 64'(b.last));
                end
            end

            // an aborted burst delivers nothing more
            if (!aresetn) begin
                ar_q.delete();
                exp_i_q.delete();
                exp_d_q.delete();
            end

            if (stim_done) break;
        end

        chk("end_ar_pending",   64'(ar_q.size()),    64'd0);
        chk("end_i_beats_left", 64'(exp_i_q.size()), 64'd0);
        chk("end_d_beats_left", 64'(exp_d_q.size()), 64'd0);
        chk("end_bus_busy",     64'(m_busy),         64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
